alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width SHALL be DATA_WIDTH bits.
REQ-002 Parameter OPCODE_LENGTH, default 4, operation code width SHALL be OPCODE_LENGTH bits.
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid_0 / req_valid_1  input  1 each  requester k presents an operation.
REQ-006 req_ready_0 / req_ready_1  output  1 each  request k accepted this cycle when valid&ready.
REQ-007 req_op_0 / req_op_1  input  OPCODE_LENGTH each  ALU operation code of requester k.
REQ-008 req_a_0, req_b_0, req_a_1, req_b_1  input  DATA_WIDTH each  operands of requester k.
REQ-009 rsp_valid_0 / rsp_valid_1  output  1 each  result for requester k held.
REQ-010 rsp_ready_0 / rsp_ready_1  input  1 each  requester k consumes result when valid&ready.
REQ-011 rsp_data_0 / rsp_data_1  output  DATA_WIDTH each  result for requester k.
REQ-012 alu_SrcA, alu_SrcB  output  DATA_WIDTH each  operands driven to the shared ALU.
REQ-013 alu_Operation  output  OPCODE_LENGTH  operation driven to the shared ALU.
REQ-014 alu_ALUResult  input  DATA_WIDTH  combinational result returned by the shared ALU.

Function
REQ-015 Block SHALL hold one result register (rsp_buf), one full flag, one owner bit and one round-robin pointer rr (port preferred on tie).
REQ-016 State SHALL be EMPTY (full=0) or HOLD (full=1); no other states.
REQ-017 can_issue = !full OR (rsp_valid_owner AND rsp_ready_owner) (drain-and-refill same cycle).
REQ-018 Grant: only one valid -> that port; both valid -> port rr; neither -> no grant.
REQ-019 req_ready_k SHALL be 1 only when port k granted AND can_issue AND reset=0; combinational.
REQ-020 Granted port's op/a/b SHALL drive alu_Operation/alu_SrcA/alu_SrcB combinationally; with no grant all three SHALL be 0.
REQ-021 On accept (req_valid_k & req_ready_k) next edge: rsp_buf <= alu_ALUResult, owner <= k, full <= 1, rr <= other port.
REQ-022 rr SHALL change only on accept; a lone requester SHALL still flip rr.
REQ-023 Latency: result visible on rsp_data_k with rsp_valid_k=1 exactly one cycle after accept.
REQ-024 rsp_valid_k = full AND owner==k; rsp_data_k = rsp_buf when owner==k, else 0.
REQ-025 Drain without new accept: full <= 0 next edge; rsp_buf retains value (don't-care).
REQ-026 While rsp_valid_k=1 and rsp_ready_k=0, rsp_data_k SHALL remain stable and no new request accepted.
REQ-027 Drain and accept same cycle: full stays 1, rsp_buf/owner take new values; no bubble; sustained throughput one op/cycle.
REQ-028 Opcode values are passed through unmodified; unsupported codes SHALL yield whatever the ALU returns (0), no error flag.
REQ-029 Arithmetic SHALL be done only by the shared ALU; block SHALL not modify result width or value.
REQ-030 Requesters SHALL hold op/a/b stable while valid and not ready; block SHALL not buffer unaccepted requests.

Reset
REQ-031 reset=1 at an edge: full <= 0, owner <= 0, rr <= 0 (port 0 preferred), rsp_buf <= 0.
REQ-032 During reset cycle req_ready_0/1 SHALL be 0; rsp_valid_0/1 SHALL be 0 from the first edge with reset=1.
REQ-033 Reset during HOLD SHALL discard the held result; no response delivered after reset.
REQ-034 First accept SHALL be possible in the first cycle with reset=0.

Verification
REQ-035 Port0 op=4'b0010 a=5 b=7, rsp_ready_0=1 -> req_ready_0=1 same cycle; next cycle rsp_valid_0=1 rsp_data_0=12, rsp_valid_1=0.
REQ-036 After reset both valid: port0 SUB 9-4, port1 OR 0xF0|0x0F -> port0 granted first (rsp 5), port1 next cycle (rsp 0xFF); rr alternates.
REQ-037 Port1 AND 0xFF&0x0F with rsp_ready_1=0 for 3 cycles, port0 valid -> rsp_data_1 held 0x0F, req_ready_0=0 throughout; port0 accepted in cycle rsp_ready_1 rises.
REQ-038 Port0 back-to-back 4 ADDs with rsp_ready_0=1 -> 4 results on 4 consecutive cycles, no bubble.
REQ-039 Port0 op=4'b1111 a=3 b=3 -> rsp_data_0=0; op=4'b1000 a=3 b=3 -> rsp_data_0=1.
REQ-040 Reset asserted while HOLD with rsp_ready_0=0 -> next cycle rsp_valid_0=0, rsp_valid_1=0; subsequent tie grants port0.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port front end for one shared combinational ALU, one op/cycle, result 1 cycle after accept.
// Backpressure: a held result stalls both request ports until its owner takes it (drain+refill same cycle).
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid_0,
  input  logic                     req_valid_1,
  output logic                     req_ready_0,
  output logic                     req_ready_1,
  input  logic [OPCODE_LENGTH-1:0] req_op_0,
  input  logic [OPCODE_LENGTH-1:0] req_op_1,
  input  logic [DATA_WIDTH-1:0]    req_a_0,
  input  logic [DATA_WIDTH-1:0]    req_b_0,
  input  logic [DATA_WIDTH-1:0]    req_a_1,
  input  logic [DATA_WIDTH-1:0]    req_b_1,
  output logic                     rsp_valid_0,
  output logic                     rsp_valid_1,
  input  logic                     rsp_ready_0,
  input  logic                     rsp_ready_1,
  output logic [DATA_WIDTH-1:0]    rsp_data_0,
  output logic [DATA_WIDTH-1:0]    rsp_data_1,
  output logic [DATA_WIDTH-1:0]    alu_SrcA,
  output logic [DATA_WIDTH-1:0]    alu_SrcB,
  output logic [OPCODE_LENGTH-1:0] alu_Operation,
  input  logic [DATA_WIDTH-1:0]    alu_ALUResult
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]            full_q, full_d;
  logic                  owner_q, owner_d;
  logic                  rr_q, rr_d;
  logic [DATA_WIDTH-1:0] rsp_buf_q, rsp_buf_d;

  logic gnt_vld, gnt_port, drain, can_issue, accept;

  always_comb begin
    gnt_vld  = 1'b0;
    gnt_port = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      gnt_vld  = 1'b1;
      gnt_port = rr_q;
    end else if (req_valid_0) begin
      gnt_vld  = 1'b1;
    end else if (req_valid_1) begin
      gnt_vld  = 1'b1;
      gnt_port = 1'b1;
    end
  end

  // A held result may leave in the same cycle a new one is captured, so the owner's ready frees the slot.
  assign drain     = (full_q == ST_HOLD) && (owner_q ? rsp_ready_1 : rsp_ready_0);
  assign can_issue = (full_q == ST_EMPTY) || drain;
  assign accept    = gnt_vld && can_issue && !reset;

  assign req_ready_0 = accept && !gnt_port;
  assign req_ready_1 = accept &&  gnt_port;

  always_comb begin
    alu_Operation = '0;
    alu_SrcA      = '0;
    alu_SrcB      = '0;
    if (gnt_vld) begin
      alu_Operation = gnt_port ? req_op_1 : req_op_0;
      alu_SrcA      = gnt_port ? req_a_1  : req_a_0;
      alu_SrcB      = gnt_port ? req_b_1  : req_b_0;
    end
  end

  always_comb begin
    full_d    = full_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    rsp_buf_d = rsp_buf_q;
    if (accept) begin
      full_d    = ST_HOLD;
      owner_d   = gnt_port;
      rr_d      = ~gnt_port;
      rsp_buf_d = alu_ALUResult;
    end else if (drain) begin
      full_d    = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q    <= ST_EMPTY;
      owner_q   <= 1'b0;
      rr_q      <= 1'b0;
      rsp_buf_q <= '0;
    end else begin
      full_q    <= full_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      rsp_buf_q <= rsp_buf_d;
    end
  end

  assign rsp_valid_0 = (full_q == ST_HOLD) && !owner_q;
  assign rsp_valid_1 = (full_q == ST_HOLD) &&  owner_q;
  assign rsp_data_0  = owner_q ? '0 : rsp_buf_q;
  assign rsp_data_1  = owner_q ? rsp_buf_q : '0;

endmodule
